// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared constants and width helpers for the MVU activation front-end
package mvu_pkg;

  localparam int SKID_DEPTH = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvu_input_replay_buffer_skid.sv
// rtl/mvu_input_replay_buffer_skid.sv - two-entry output skid carrying {tlast, tdata}
module replay_skid
  import mvu_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flight,
  output logic             has_room,
  output logic             full,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;
  logic [2:0]       load;

  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid && out_ready;
  assign full      = (count == 2'(SKID_DEPTH));

  // Occupancy after this edge if one more read issues now: held entries plus
  // the beat still in the RAM read stage, minus the beat leaving this cycle.
  assign load     = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
  assign has_room = (load < 3'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mvu_input_replay_buffer.sv
// rtl/mvu_input_replay_buffer.sv - captures activation vectors and replays each one NF times
module mvu_input_replay_buffer
  import mvu_pkg::*;
#(
  parameter int SIMD             = 48,
  parameter int ACTIVATION_WIDTH = 4,
  parameter int SF               = 2,
  parameter int NF               = 2,
  parameter int SLOTS            = 2,
  parameter int BYPASS_NF1       = 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [SIMD*ACTIVATION_WIDTH-1:0] s_axis_input_tdata,
  input  logic                             s_axis_input_tvalid,
  output logic                             s_axis_input_tready,
  output logic [SIMD*ACTIVATION_WIDTH-1:0] m_axis_output_tdata,
  output logic                             m_axis_output_tvalid,
  input  logic                             m_axis_output_tready,
  output logic                             m_axis_output_tlast
);

  localparam int    W         = SIMD * ACTIVATION_WIDTH;
  localparam bit    BYPASS    = (BYPASS_NF1 != 0) && (NF == 1);
  localparam int    SW        = clog2_min1(SLOTS);
  localparam int    BW        = clog2_min1(SF);
  localparam int    PW        = clog2_min1(NF);
  localparam int    OW        = $clog2(SLOTS + 1);
  localparam int    DEPTH     = SLOTS * SF;
  localparam int    AD        = clog2_min1(DEPTH);
  localparam string RAM_STYLE = (DEPTH <= 64) ? "distributed" : "block";

  typedef logic [SIMD-1:0][ACTIVATION_WIDTH-1:0] activation_t;

  (* ram_style = RAM_STYLE *) activation_t mem [DEPTH];

  logic [SW-1:0] wslot, rslot;
  logic [BW-1:0] wbeat, rbeat;
  logic [PW-1:0] rpass;
  logic [OW-1:0] occ;
  logic [AD-1:0] waddr, raddr;
  activation_t   rd_data;
  logic          rd_valid, rd_last;
  logic          wr_en, vec_done, rd_issue, slot_release;
  logic          skid_room, skid_full, skid_in_valid, skid_in_flight;
  logic [W:0]    skid_in, skid_out;

  assign s_axis_input_tready = !ap_rst && (BYPASS ? !skid_full : (occ != OW'(SLOTS)));
  assign wr_en        = s_axis_input_tvalid && s_axis_input_tready;
  assign vec_done     = wr_en && (wbeat == BW'(SF - 1));
  assign rd_issue     = !BYPASS && (occ != '0) && skid_room;
  assign slot_release = rd_issue && (rbeat == BW'(SF - 1)) && (rpass == PW'(NF - 1));
  assign waddr        = AD'(int'(wslot) * SF + int'(wbeat));
  assign raddr        = AD'(int'(rslot) * SF + int'(rbeat));

  always_ff @(posedge ap_clk) begin
    if (wr_en && !BYPASS) mem[waddr] <= s_axis_input_tdata;
    if (rd_issue) rd_data <= mem[raddr];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wslot    <= '0;
      wbeat    <= '0;
      rslot    <= '0;
      rbeat    <= '0;
      rpass    <= '0;
      occ      <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wbeat == BW'(SF - 1)) begin
          wbeat <= '0;
          wslot <= (wslot == SW'(SLOTS - 1)) ? '0 : wslot + 1'b1;
        end else begin
          wbeat <= wbeat + 1'b1;
        end
      end
      if (rd_issue) begin
        if (rbeat == BW'(SF - 1)) begin
          rbeat <= '0;
          if (rpass == PW'(NF - 1)) begin
            rpass <= '0;
            rslot <= (rslot == SW'(SLOTS - 1)) ? '0 : rslot + 1'b1;
          end else begin
            rpass <= rpass + 1'b1;
          end
        end else begin
          rbeat <= rbeat + 1'b1;
        end
      end
      // A vector landing on the same edge another is released nets to zero.
      if (vec_done && !slot_release && !BYPASS) occ <= occ + 1'b1;
      else if (!vec_done && slot_release) occ <= occ - 1'b1;
      rd_valid <= rd_issue;
      rd_last  <= (rbeat == BW'(SF - 1));
    end
  end

  assign skid_in_valid  = BYPASS ? wr_en : rd_valid;
  assign skid_in_flight = BYPASS ? 1'b0 : rd_valid;
  assign skid_in        = BYPASS ? {(wbeat == BW'(SF - 1)), s_axis_input_tdata} : {rd_last, rd_data};

  replay_skid #(.WIDTH(W + 1)) u_skid (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .in_valid  (skid_in_valid),
    .in_data   (skid_in),
    .in_flight (skid_in_flight),
    .has_room  (skid_room),
    .full      (skid_full),
    .out_valid (m_axis_output_tvalid),
    .out_data  (skid_out),
    .out_ready (m_axis_output_tready)
  );

  assign m_axis_output_tdata = skid_out[W-1:0];
  assign m_axis_output_tlast = m_axis_output_tvalid && skid_out[W];

endmodule
